uart_tx_fifo: RTL and testbench

Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises them onto a single line as 8N1/8E1/8O1 (or 2-stop) frames at a fixed baud rate. It is the transmit-side counterpart of the team's UART receiver. It drives the line that receiver samples, for board loopback and host links. Bit timing is derived from the system clock by an internal divider; no external baud clock is used.

---
 rtl/uart_tx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : FIFO-buffered UART transmitter, 8 data bits, optional
//                even/odd parity, one or two stop bits, internal baud divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int F_CLK_HZ   = 50_000_000,
    parameter int BAUD       = 100_000,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int c_DIV = F_CLK_HZ / BAUD;
    localparam int c_DW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_AW  = $clog2(FIFO_DEPTH);

    localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(c_DIV - 1);
    localparam logic [2:0]      c_STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------- FIFO ----------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          r_tx_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [c_AW:0] w_count;
    logic [c_AW:0] w_count_nx;
    logic [7:0]    w_head;

    assign w_push     = tx_valid & r_tx_ready;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_count_nx = w_count + (c_AW + 1)'(w_push) - (c_AW + 1)'(w_pop);
    assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_tx_ready <= (w_count_nx != c_FULL);
        end
    end

    // ---------------- Framer ----------------
    logic [2:0]      r_state,  w_state_nx;
    logic [c_DW-1:0] r_div,    w_div_nx;
    logic [2:0]      r_idx,    w_idx_nx;
    logic [7:0]      r_data,   w_data_nx;
    logic            r_tx,     w_tx_nx;
    logic            w_tick;
    logic            w_done;
    logic            w_par;

    assign w_tick = (r_div == '0);
    assign w_par  = (PARITY == 1) ? ^r_data : ~^r_data;

    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div;
        w_idx_nx   = r_idx;
        w_data_nx  = r_data;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        w_done     = 1'b0;

        // Shared divider: reload on every bit boundary, count down otherwise
        if (r_state != S_IDLE) begin
            w_div_nx = w_tick ? c_DIV_LAST : r_div - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_data_nx  = w_head;
                    w_state_nx = S_START;
                    w_div_nx   = c_DIV_LAST;
                    w_idx_nx   = 3'd0;
                    w_tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nx = S_DATA;
                    w_idx_nx   = 3'd0;
                    w_tx_nx    = r_data[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_idx == 3'd7) begin
                        w_idx_nx = 3'd0;
                        if (PARITY != 0) begin
                            w_state_nx = S_PARITY;
                            w_tx_nx    = w_par;
                        end else begin
                            w_state_nx = S_STOP;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                        w_tx_nx  = r_data[r_idx + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nx = S_STOP;
                    w_idx_nx   = 3'd0;
                    w_tx_nx    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_idx == c_STOP_LAST) begin
                        w_done   = 1'b1;
                        w_idx_nx = 3'd0;
                        // Chain straight into the next frame when data is waiting
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_data_nx  = w_head;
                            w_state_nx = S_START;
                            w_tx_nx    = 1'b0;
                        end else begin
                            w_state_nx = S_IDLE;
                            w_div_nx   = '0;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_div_nx   = '0;
                w_idx_nx   = 3'd0;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_idx   <= 3'd0;
            r_data  <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_idx   <= w_idx_nx;
            r_data  <= w_data_nx;
            r_tx    <= w_tx_nx;
        end
    end

    assign tx_ready = r_tx_ready;
    assign uart_tx  = r_tx;
    assign busy     = (r_state != S_IDLE);
    assign tx_done  = w_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Bench for uart_tx_fifo; three instances (8N1, 8E2, 8O1) at
//                10 clocks per bit, frame decoders popping an expected queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [7:0] tx_data [3];
    logic [2:0] tx_valid;
    logic [2:0] tx_ready;
    logic [2:0] line;
    logic [2:0] busy;
    logic [2:0] tx_done;

    int checks = 0;
    int errors = 0;

    // Expected frames: {parity bit, data byte}
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [8:0] q2 [$];

    task automatic check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push_exp(input int idx, input logic [8:0] v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int idx, output logic [8:0] v, output logic empty);
        v     = '0;
        empty = 1'b0;
        case (idx)
            0:       if (q0.size() == 0) empty = 1'b1; else v = q0.pop_front();
            1:       if (q1.size() == 0) empty = 1'b1; else v = q1.pop_front();
            default: if (q2.size() == 0) empty = 1'b1; else v = q2.pop_front();
        endcase
    endtask

    task automatic mon_wait(input int idx, input int n, inout logic ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst[idx]) ab = 1'b1;
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int P = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int S = (g == 1) ? 2 : 1;

        uart_tx_fifo #(
            .F_CLK_HZ  (1_000_000),
            .BAUD      (100_000),
            .PARITY    (P),
            .STOP_BITS (S),
            .FIFO_DEPTH(4)
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .tx_data (tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .uart_tx (line[g]),
            .busy    (busy[g]),
            .tx_done (tx_done[g])
        );

        // Frame decoder: samples each bit mid-period and scores against the queue
        initial begin
            logic       ab;
            logic       st_ok;
            logic       pb;
            logic       emp;
            logic [7:0] d;
            logic [8:0] e;
            forever begin
                @(negedge clk);
                if (!rst[g] && !line[g]) begin
                    ab = 1'b0;
                    d  = 8'h00;
                    pb = 1'b0;
                    mon_wait(g, 4, ab);
                    st_ok = !line[g];
                    for (int i = 0; i < 8; i++) begin
                        mon_wait(g, 10, ab);
                        d[i] = line[g];
                    end
                    if (P != 0) begin
                        mon_wait(g, 10, ab);
                        pb = line[g];
                    end
                    for (int i = 0; i < S; i++) begin
                        mon_wait(g, 10, ab);
                        if (!line[g]) st_ok = 1'b0;
                    end
                    if (!ab) begin
                        pop_exp(g, e, emp);
                        if (emp) begin
                            checks++;
                            errors++;
                            $display("FAIL mon%0d unexpected frame: got data %02h expected no frame", g, d);
                        end else begin
                            check8($sformatf("mon%0d data", g), d, e[7:0]);
                            if (P != 0) check($sformatf("mon%0d parity of %02h", g, e[7:0]), pb, e[8]);
                            check($sformatf("mon%0d framing of %02h", g, e[7:0]), st_ok, 1'b1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] vec [6];
        logic       e_line;
        int         lows, dones, busys;

        rst      = 3'b111;
        tx_valid = 3'b000;
        for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset uart_tx[%0d]", i), line[i], 1'b1);
            check($sformatf("reset busy[%0d]", i), busy[i], 1'b0);
            check($sformatf("reset tx_done[%0d]", i), tx_done[i], 1'b0);
            check($sformatf("reset tx_ready[%0d]", i), tx_ready[i], 1'b1);
        end
        rst = 3'b000;

        // Single 8N1 frame of 0x55
        pat = 8'h55;
        @(negedge clk);
        tx_data[0] = 8'h55; tx_valid[0] = 1'b1;
        push_exp(0, {1'b0, 8'h55});
        for (int t = 0; t <= 105; t++) begin
            @(posedge clk); #1;
            if (t == 0) tx_valid[0] = 1'b0;
            if (t == 0)       e_line = 1'b1;
            else if (t <= 10) e_line = 1'b0;
            else if (t <= 90) e_line = pat[3'((t - 11) / 10)];
            else              e_line = 1'b1;
            check($sformatf("p1 uart_tx t=%0d", t), line[0], e_line);
            check($sformatf("p1 busy t=%0d", t), busy[0], (t >= 1 && t <= 100));
            check($sformatf("p1 tx_done t=%0d", t), tx_done[0], (t == 100));
        end

        // 0x07 on even/2-stop and odd/1-stop, then 0x3C queued behind on even
        @(negedge clk);
        tx_data[1] = 8'h07; tx_valid[1] = 1'b1;
        tx_data[2] = 8'h07; tx_valid[2] = 1'b1;
        push_exp(1, {1'b1, 8'h07});
        push_exp(2, {1'b0, 8'h07});
        for (int t = 0; t <= 250; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                tx_valid[2] = 1'b0;
                tx_data[1]  = 8'h3C;
                push_exp(1, {1'b0, 8'h3C});
            end
            if (t == 1) tx_valid[1] = 1'b0;
            check($sformatf("p2 odd tx_done t=%0d", t), tx_done[2], (t == 110));
            check($sformatf("p2 odd busy t=%0d", t), busy[2], (t >= 1 && t <= 110));
            check($sformatf("p2 even tx_done t=%0d", t), tx_done[1], (t == 120 || t == 240));
            check($sformatf("p2 even busy t=%0d", t), busy[1], (t >= 1 && t <= 240));
            if (t >= 101 && t <= 120) check($sformatf("p2 even stop t=%0d", t), line[1], 1'b1);
            if (t == 121) check("p2 even back-to-back start", line[1], 1'b0);
        end

        // Six consecutive pushes into a depth-4 FIFO; the sixth is refused
        vec = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h11};
        @(negedge clk);
        tx_data[0] = vec[0]; tx_valid[0] = 1'b1;
        push_exp(0, {1'b0, 8'hA5});
        push_exp(0, {1'b0, 8'h3C});
        push_exp(0, {1'b0, 8'hFF});
        push_exp(0, {1'b0, 8'h00});
        push_exp(0, {1'b0, 8'h81});
        for (int t = 0; t <= 505; t++) begin
            @(posedge clk); #1;
            if (t < 5) tx_data[0] = vec[t + 1];
            else       tx_valid[0] = 1'b0;
            check($sformatf("p3 tx_ready t=%0d", t), tx_ready[0], !(t >= 4 && t <= 100));
            check($sformatf("p3 tx_done t=%0d", t), tx_done[0], (t >= 100 && t <= 500 && (t % 100) == 0));
            check($sformatf("p3 busy t=%0d", t), busy[0], (t >= 1 && t <= 500));
        end

        // Reset during data bit 3 with a second byte queued, plus a push on the reset edge
        @(negedge clk);
        tx_data[0] = 8'h12; tx_valid[0] = 1'b1;
        lows = 0; dones = 0; busys = 0;
        for (int t = 0; t <= 300; t++) begin
            @(posedge clk); #1;
            if (t == 0) tx_data[0] = 8'h34;
            if (t == 1) tx_valid[0] = 1'b0;
            if (t == 45) begin
                check("p4 busy before reset", busy[0], 1'b1);
                rst[0] = 1'b1; tx_valid[0] = 1'b1; tx_data[0] = 8'h77;
            end
            if (t == 46) begin
                check("p4 uart_tx after reset", line[0], 1'b1);
                check("p4 busy after reset", busy[0], 1'b0);
                check("p4 tx_ready after reset", tx_ready[0], 1'b1);
                rst[0] = 1'b0; tx_valid[0] = 1'b0;
            end
            if (t >= 46) begin
                if (!line[0])  lows++;
                if (busy[0])   busys++;
            end
            if (tx_done[0]) dones++;
        end
        check_int("p4 low clocks after reset", lows, 0);
        check_int("p4 busy clocks after reset", busys, 0);
        check_int("p4 tx_done pulses", dones, 0);

        // Push during the stop bit of a lone frame
        @(negedge clk);
        tx_data[0] = 8'h5A; tx_valid[0] = 1'b1;
        push_exp(0, {1'b0, 8'h5A});
        for (int t = 0; t <= 205; t++) begin
            @(posedge clk); #1;
            if (t == 0) tx_valid[0] = 1'b0;
            if (t == 94) begin
                tx_data[0] = 8'h0F; tx_valid[0] = 1'b1;
                push_exp(0, {1'b0, 8'h0F});
            end
            if (t == 95) tx_valid[0] = 1'b0;
            if (t == 100) begin
                check("p5 last stop clock", line[0], 1'b1);
                check("p5 tx_done frame 1", tx_done[0], 1'b1);
            end
            if (t == 101) begin
                check("p5 immediate start", line[0], 1'b0);
                check("p5 busy continuous", busy[0], 1'b1);
            end
            if (t == 200) check("p5 tx_done frame 2", tx_done[0], 1'b1);
            if (t == 201) check("p5 idle after frame 2", busy[0], 1'b0);
        end

        repeat (20) @(posedge clk);
        check_int("q0 leftover frames", q0.size(), 0);
        check_int("q1 leftover frames", q1.size(), 0);
        check_int("q2 leftover frames", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
